down_counter_load_timer: RTL and testbench
==========================================

# down_counter_load_timer

Parameterized synchronous down counter with a loadable start value, count enable, terminal-count pulse and one-shot or auto-reload modes. It counts toward zero and flags expiry, complementing the team's free-running up counters. Used as the programmable interval/timeout timer in counter-based sequencing logic. All state is updated on the rising clock edge, with an asynchronous clear.

## Interface
- BITS, 4, width of counter, reload register and load value (≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  synchronous load strobe; copies load_val into the count and the reload register
- load_val  input  BITS  value captured on load
- start  input  1  begins counting from IDLE or DONE
- en  input  1  count enable; when low, the count holds while in RUN
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at every expiry
- q  output  BITS  current count, true polarity (not inverted)
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide
- busy  output  1  high while state is RUN
- done  output  1  high while state is DONE (one-shot expired)

## Operation
- State machine: IDLE, RUN, DONE. It is registered and encoded in 2 bits.
- Reset (async, reset_n=0):
  - q=0, reload register=0, tc=0.
  - State=IDLE, so busy=0 and done=0.
- Priority on each edge: load > start > count.
- load=1, in any state:
  - q<=load_val, reload<=load_val.
  - State<=IDLE and tc<=0.
  - A start asserted in the same cycle is ignored.
- start=1 with load=0:
  - From IDLE or DONE, state<=RUN. q is unchanged.
  - In RUN, start is ignored.
- RUN with en=1:
  - q≠0: q<=q−1, tc<=0.
  - q=0 and auto_reload=1: tc<=1, q<=reload, stay in RUN.
  - q=0 and auto_reload=0: tc<=1, q stays 0, state<=DONE.
- RUN with en=0: q holds, tc<=0.
- tc is 0 on every edge not listed above, so it is never high for two consecutive cycles unless reload=0 with auto_reload=1.
- Arithmetic:
  - Decrement is modulo-free. q never goes below 0 and never wraps to all-ones.
  - The maximum load is 2^BITS−1.
- reload=0 with auto_reload=1: tc is high on every enabled cycle and q stays 0.
- start from DONE without a new load: q is 0, so it expires on the first enabled cycle.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- start sampled at edge k: busy=1 after edge k.
- The first decrement happens at the first edge after k with en=1.
- One-shot, load value N, en held 1, start at edge k:
  - q=0 after edge k+N.
  - tc=1 and done=1 after edge k+N+1.
  - tc=0 after edge k+N+2; done stays high.
- Auto-reload period: N+1 enabled cycles between tc pulses.
- load takes effect on the next edge. q shows load_val one cycle after the strobe.
- reset_n asserted mid-count clears every output immediately, independent of clk. Counting resumes only after a new load and start.
- reset_n deassertion is synchronized externally. The block requires at least one clean edge before load.

## Test plan
- Reset: reset_n=0 mid-count with q=9 (BITS=4) -> q=0, tc=0, busy=0, done=0 immediately and without a clock edge.
- One-shot, BITS=4:
  - Stimulus: load 3, start, en=1, auto_reload=0.
  - q sequence is 3,2,1,0. tc=1 for exactly one cycle at the 4th enabled edge after RUN entry.
  - done=1 and busy=0 from then on. q stays 0 for 10 more cycles.
- Auto-reload with en gating:
  - Stimulus: load 2, auto_reload=1, en toggled 1,0,1,1,0,1.
  - q holds on en=0. tc pulses on the 3rd enabled cycle and q returns to 2.
  - With en=1 constant, the tc period is exactly 3 cycles over 5 periods.
- Load priority: load=1 with load_val=15 and start=1 in the same cycle while in RUN at q=5 -> q=15, state IDLE, busy=0, no tc.
- Boundaries:
  - load 0 with auto_reload=1 and en=1 -> tc high every cycle, q=0.
  - load 15 one-shot -> 16 enabled cycles to tc, with no underflow to 15.
- Restart: from DONE, start again without load -> tc after 1 enabled cycle. Then load 1 and start -> tc after 2 enabled cycles.

Source files
------------

// File: rtl/down_counter_load_timer_if.sv
// Control and status bundle for the loadable down-counter timer.
// The master drives the controls and the slave (the timer) returns the status.
interface down_counter_load_timer_if #(
   parameter int unsigned BITS = 4
);
   logic            load;
   logic [BITS-1:0] load_val;
   logic            start;
   logic            en;
   logic            auto_reload;
   logic [BITS-1:0] q;
   logic            tc;
   logic            busy;
   logic            done;

   modport master (
      output load, load_val, start, en, auto_reload,
      input  q, tc, busy, done
   );

   modport slave (
      input  load, load_val, start, en, auto_reload,
      output q, tc, busy, done
   );
endinterface

// File: rtl/down_counter_load_timer.sv
// Programmable interval/timeout timer: counts a loaded value down to zero,
// pulses tc at expiry, then either reloads (periodic) or parks in DONE (one-shot).
module down_counter_load_timer #(
   parameter int unsigned BITS = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   down_counter_load_timer_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [BITS-1:0] q_q, q_d;
   logic [BITS-1:0] reload_q, reload_d;
   logic            tc_q, tc_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         q_q      <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next state: load beats start, start beats counting.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (bus.load) begin
         q_d      = bus.load_val;
         reload_d = bus.load_val;
         state_d  = IDLE;
      end else if (bus.start && (state_q != RUN)) begin
         state_d = RUN;
      end else if ((state_q == RUN) && bus.en) begin
         if (q_q != '0) begin
            q_d = q_q - BITS'(1);
         end else begin
            // Expiry: zero is held one enabled cycle before tc fires.
            tc_d = 1'b1;
            if (bus.auto_reload) begin
               q_d = reload_q;
            end else begin
               state_d = DONE;
            end
         end
      end

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign bus.q    = q_q;
   assign bus.tc   = tc_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_down_counter_load_timer.sv
// Directed bench for down_counter_load_timer: a vector table for the main
// sequences plus hand-written multi-cycle checks for periods, boundaries and reset.
module tb_down_counter_load_timer;

   localparam int unsigned BITS = 4;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   down_counter_load_timer_if #(.BITS(BITS)) bus ();

   down_counter_load_timer #(.BITS(BITS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic            load;
      logic [BITS-1:0] lv;
      logic            start;
      logic            en;
      logic            ar;
      logic [BITS-1:0] q;
      logic            tc;
      logic            busy;
      logic            done;
   } vec_t;

   vec_t vecs[25];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [BITS-1:0] eq,
                        input logic etc, input logic ebusy, input logic edone);
      checks++;
      if (bus.q !== eq || bus.tc !== etc || bus.busy !== ebusy || bus.done !== edone) begin
         failures++;
         $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
                  name, bus.q, bus.tc, bus.busy, bus.done, eq, etc, ebusy, edone);
      end
   endtask

   task automatic drive(input logic l, input logic [BITS-1:0] lv, input logic s,
                        input logic e, input logic ar);
      bus.load        = l;
      bus.load_val    = lv;
      bus.start       = s;
      bus.en          = e;
      bus.auto_reload = ar;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].en, vecs[i].ar);
         tick();
         check($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].busy, vecs[i].done);
      end
   endtask

   initial begin
      int pulses;

      //            load  lv    st    en    ar    q     tc    busy  done
      // one-shot, load 3
      vecs[0]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
      // auto-reload, load 2, en 1,0,1,1,0,1
      vecs[7]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0};
      // load priority over start while running at q=5
      vecs[15] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
      // reload 0 in periodic mode: tc every enabled cycle
      vecs[20] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[22] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[23] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[24] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};

      reset_n = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      #12;
      check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

      run_vecs(0, 6);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("done_hold%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
      end
      run_vecs(7, 24);

      // Periodic mode, en held high: tc every 3rd cycle for 5 periods.
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      pulses = 0;
      for (int i = 1; i <= 15; i++) begin
         logic [BITS-1:0] eq;
         tick();
         eq = (i % 3 == 1) ? 4'd1 : (i % 3 == 2) ? 4'd0 : 4'd2;
         if (bus.tc === 1'b1) pulses++;
         check($sformatf("period_c%0d", i), eq, (i % 3 == 0), 1'b1, 1'b0);
      end
      checks++;
      if (pulses != 5) begin
         failures++;
         $display("FAIL period_count: got %0d pulses, expected 5", pulses);
      end

      // One-shot from max load: 16 enabled cycles to tc, no wrap.
      drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("max_c%0d", i), (i < 16) ? 4'(15 - i) : 4'd0,
               (i == 16), (i != 16), (i == 16));
      end
      tick();
      check("max_no_wrap", 4'd0, 1'b0, 1'b0, 1'b1);

      // Restart from DONE without load: expires on first enabled cycle.
      drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check("restart_start", 4'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      check("restart_tc", 4'd0, 1'b1, 1'b0, 1'b1);

      // Load 1 then start: tc after 2 enabled cycles.
      drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      tick();
      check("load1_start", 4'd1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      check("load1_c1", 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      check("load1_c2", 4'd0, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset while running at q=9.
      drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      check("pre_reset_q9", 4'd9, 1'b0, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      check("after_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
